// File: rtl/prefetch_buffer_if.sv
// Prefetch buffer bus bundle.
//   Program memory: pm_addr (fetch pointer), pm_opcode/pm_operand (combinational read data)
//   Control:        stall (decode not accepting), flush/flush_addr (redirect)
//   Head entry:     valid_out, oc_out, or_out, npc_out, count (occupancy 0..DEPTH)
// slave  = the prefetch buffer itself
// master = the surrounding core (program memory + decode/branch logic)
interface prefetch_buffer_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [7:0]    pm_addr;
   logic [7:0]    pm_opcode;
   logic [7:0]    pm_operand;
   logic          stall;
   logic          flush;
   logic [7:0]    flush_addr;
   logic          valid_out;
   logic [7:0]    oc_out;
   logic [7:0]    or_out;
   logic [7:0]    npc_out;
   logic [CW-1:0] count;

   modport slave (
      output pm_addr, valid_out, oc_out, or_out, npc_out, count,
      input  pm_opcode, pm_operand, stall, flush, flush_addr
   );

   modport master (
      input  pm_addr, valid_out, oc_out, or_out, npc_out, count,
      output pm_opcode, pm_operand, stall, flush, flush_addr
   );
endinterface

// File: rtl/prefetch_buffer.sv
// Instruction prefetch queue.
// Fetches one {opcode, operand} per cycle from program memory at the fetch
// pointer into a DEPTH-entry circular queue, tagging each entry with its
// address + 1 (next PC). The head entry is presented to decode; stall holds it,
// flush discards the queue and redirects fetch to flush_addr.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset (wins over flush)
//   bus  - prefetch_buffer_if.slave (pm_*, stall, flush*, head outputs, count)
module prefetch_buffer #(
   parameter int         DEPTH  = 4,
   parameter logic [7:0] NOP_OC = 8'h00
) (
   input logic              clk,
   input logic              rst,
   prefetch_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);

   logic [7:0]    fpc_q, fpc_d;
   logic [AW-1:0] head_q, head_d, tail_q, tail_d;
   logic [AW:0]   count_q, count_d;

   // Queue storage; never reset, validity is tracked by count_q alone.
   logic [7:0] oc_mem  [DEPTH];
   logic [7:0] or_mem  [DEPTH];
   logic [7:0] npc_mem [DEPTH];

   logic valid, pop, push;

   assign valid = (count_q != '0);
   assign pop   = valid & ~bus.stall & ~bus.flush;
   // A full queue can still accept when the head leaves the same cycle.
   assign push  = ~bus.flush & ((count_q < FULL) | pop);

   always_comb begin
      fpc_d   = fpc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (bus.flush) begin
         fpc_d   = bus.flush_addr;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) begin
            tail_d = tail_q + PTR_ONE;     // DEPTH is a power of two: natural wrap
            fpc_d  = fpc_q + 8'd1;
         end
         if (pop) head_d = head_q + PTR_ONE;
         if (push && !pop) count_d = count_q + CNT_ONE;
         else if (pop && !push) count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc_q   <= 8'h00;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         fpc_q   <= fpc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         oc_mem[tail_q]  <= bus.pm_opcode;
         or_mem[tail_q]  <= bus.pm_operand;
         npc_mem[tail_q] <= fpc_q + 8'd1;
      end
   end

   // Head outputs come only from stored state; an empty queue shows a NOP
   // whose next PC is the pending fetch address.
   assign bus.pm_addr   = fpc_q;
   assign bus.valid_out = valid;
   assign bus.oc_out    = valid ? oc_mem[head_q]  : NOP_OC;
   assign bus.or_out    = valid ? or_mem[head_q]  : 8'h00;
   assign bus.npc_out   = valid ? npc_mem[head_q] : fpc_q;
   assign bus.count     = count_q;
endmodule

// File: tb/tb_prefetch_buffer.sv
module tb_prefetch_buffer;
   localparam int         DEPTH  = 4;
   localparam logic [7:0] NOP_OC = 8'h00;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   prefetch_buffer_if #(.DEPTH(DEPTH)) bus ();
   prefetch_buffer #(.DEPTH(DEPTH), .NOP_OC(NOP_OC)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [7:0] pm_oc [256];
   logic [7:0] pm_or [256];
   assign bus.pm_opcode  = pm_oc[bus.pm_addr];
   assign bus.pm_operand = pm_or[bus.pm_addr];

   // Reference model: a queue of {opcode, operand, npc} and a fetch pointer.
   logic [23:0] mq [$];
   logic [7:0]  m_fpc;
   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      bit v;
      v = (mq.size() != 0);
      chk("pm_addr",   32'(bus.pm_addr),   32'(m_fpc));
      chk("valid_out", 32'(bus.valid_out), 32'(v));
      chk("oc_out",    32'(bus.oc_out),    v ? 32'(mq[0][23:16]) : 32'(NOP_OC));
      chk("or_out",    32'(bus.or_out),    v ? 32'(mq[0][15:8])  : 32'h0);
      chk("npc_out",   32'(bus.npc_out),   v ? 32'(mq[0][7:0])   : 32'(m_fpc));
      chk("count",     32'(bus.count),     32'(mq.size()));
   endtask

   task automatic model_edge(input bit r, input bit s, input bit f, input logic [7:0] fa);
      bit pop, push;
      if (r) begin
         mq.delete();
         m_fpc = 8'h00;
      end else if (f) begin
         mq.delete();
         m_fpc = fa;
      end else begin
         pop  = (mq.size() != 0) && !s;
         push = (mq.size() < DEPTH) || pop;
         if (pop) void'(mq.pop_front());
         if (push) begin
            mq.push_back({pm_oc[m_fpc], pm_or[m_fpc], m_fpc + 8'd1});
            m_fpc = m_fpc + 8'd1;
         end
      end
   endtask

   // One clock cycle: drive inputs, check pre-edge outputs, advance model and DUT.
   task automatic step(input bit r, input bit s, input bit f, input logic [7:0] fa);
      rst = r; bus.stall = s; bus.flush = f; bus.flush_addr = fa;
      #1;
      if (chk_en) check_all();
      model_edge(r, s, f, fa);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.stall = 1'b0; bus.flush = 1'b0; bus.flush_addr = 8'h00;
      for (int i = 0; i < 256; i++) begin
         pm_oc[i] = 8'($urandom);
         pm_or[i] = 8'($urandom);
      end
      pm_oc[0] = 8'h11; pm_or[0] = 8'hA0;
      pm_oc[1] = 8'h22; pm_or[1] = 8'hA1;
      pm_oc[2] = 8'h33; pm_or[2] = 8'hA2;
      pm_oc[3] = 8'h44; pm_or[3] = 8'hA3;
      m_fpc = 8'h00;

      // Reset, then free-running fetch from address 0.
      step(1, 0, 0, 8'h00);
      chk_en = 1;
      step(1, 0, 0, 8'h00);
      chk("rst_pm_addr", 32'(bus.pm_addr), 32'h00);
      chk("rst_valid",   32'(bus.valid_out), 32'h0);
      step(0, 0, 0, 8'h00);
      chk("first_oc",  32'(bus.oc_out),  32'h11);
      chk("first_or",  32'(bus.or_out),  32'hA0);
      chk("first_npc", 32'(bus.npc_out), 32'h01);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00);
      chk("stream_oc", 32'(bus.oc_out), 32'h44);
      chk("stream_cnt", 32'(bus.count), 32'h1);

      // Stall from reset: fill to DEPTH, fetch stops at 04.
      step(1, 1, 0, 8'h00);
      for (int i = 0; i < 6; i++) step(0, 1, 0, 8'h00);
      chk("stall_pm_addr", 32'(bus.pm_addr), 32'h04);
      chk("stall_npc",     32'(bus.npc_out), 32'h01);
      chk("stall_cnt",     32'(bus.count),   32'h4);
      // One-cycle release while full: pop + push on the same edge.
      step(0, 0, 0, 8'h00);
      chk("full_pm_addr", 32'(bus.pm_addr), 32'h05);
      chk("full_cnt",     32'(bus.count),   32'h4);
      chk("full_oc",      32'(bus.oc_out),  32'h22);

      // Flush to 0x40 with count = 3.
      step(1, 1, 0, 8'h00);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
      step(0, 1, 1, 8'h40);
      chk("flush_valid", 32'(bus.valid_out), 32'h0);
      chk("flush_addr",  32'(bus.pm_addr),   32'h40);
      step(0, 0, 0, 8'h00);
      chk("flush_tgt_oc",  32'(bus.oc_out),  32'(pm_oc[8'h40]));
      chk("flush_tgt_npc", 32'(bus.npc_out), 32'h41);

      // Address wrap through FF.
      step(0, 0, 1, 8'hFE);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00);

      // Reset concurrent with flush: reset wins.
      step(0, 1, 0, 8'h00);
      step(1, 0, 1, 8'h80);
      chk("rstflush_addr", 32'(bus.pm_addr), 32'h00);
      chk("rstflush_cnt",  32'(bus.count),   32'h0);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++)
         step(($urandom_range(99) < 2), ($urandom_range(99) < 45),
              ($urandom_range(99) < 6), 8'($urandom));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/prefetch_buffer.md
PREFETCH_BUFFER -- requirements
Module: prefetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, queue entries (power of two, 2..8).
REQ-002 Parameter NOP_OC, default 8'h00, opcode presented while queue empty.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pm_addr  output  8  program memory address (current fetch pointer).
REQ-006 pm_opcode  input  8  program memory opcode at pm_addr, valid same cycle (combinational read).
REQ-007 pm_operand  input  8  program memory operand at pm_addr, valid same cycle.
REQ-008 stall  input  1  downstream decode stage not accepting; head entry held.
REQ-009 flush  input  1  taken branch/call/return; discard queue, redirect fetch.
REQ-010 flush_addr  input  8  new fetch address, sampled when flush=1.
REQ-011 valid_out  output  1  head entry present.
REQ-012 oc_out  output  8  head opcode (feeds opcode register stage).
REQ-013 or_out  output  8  head operand (feeds operand register stage).
REQ-014 npc_out  output  8  head instruction address + 1, mod 256 (feeds NPC buffer).
REQ-015 count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-016 Fetch pointer fpc is an 8-bit register; pm_addr SHALL equal fpc combinationally.
REQ-017 pop = valid_out & ~stall & ~flush.
REQ-018 push = ~flush & (count < DEPTH | pop).
REQ-019 On push: entry {pm_opcode, pm_operand, fpc+1} written at tail; fpc <= fpc+1, 8'hFF wraps to 8'h00.
REQ-020 On pop: head advances one entry; simultaneous push+pop leaves count unchanged.
REQ-021 When full without pop: no write, fpc holds, count stays DEPTH.
REQ-022 Outputs SHALL come from stored queue state only, never combinationally from pm_* inputs.
REQ-023 valid_out = (count != 0).
REQ-024 When count = 0: oc_out = NOP_OC, or_out = 8'h00, npc_out = fpc.
REQ-025 Flush: at next edge count <= 0, head/tail pointers reset, fpc <= flush_addr; no push or pop occurs in the flush cycle.
REQ-026 Flush has priority over stall, push and pop; rst has priority over flush.
REQ-027 Latency: instruction at address A, fetched with queue not full in cycle t, appears at head in cycle t+1 if queue was empty.
REQ-028 Redirect penalty: flush in cycle t -> valid_out = 0 in t+1, first target instruction valid in t+2.
REQ-029 Stall held indefinitely: head outputs stable; queue fills to DEPTH then fetch stops.
REQ-030 Head/tail pointers wrap modulo DEPTH; count never exceeds DEPTH or underflows below 0.

Reset
REQ-031 While rst=1 at posedge: fpc <= 8'h00, count <= 0, pointers <= 0; storage contents need not be cleared.
REQ-032 Post-reset outputs: pm_addr = 8'h00, valid_out = 0, oc_out = NOP_OC, or_out = 8'h00, npc_out = 8'h00, count = 0.
REQ-033 rst asserted mid-fill or concurrent with flush: reset values win, flush_addr ignored.

Verification
REQ-034 Reset, stall=0, PM[0..3] = {11/A0, 22/A1, 33/A2, 44/A3} -> cycle 1: oc_out=11, or_out=A0, npc_out=01; one instruction per cycle thereafter, count stays 1.
REQ-035 stall=1 from reset for 6 cycles -> count rises 1,2,3,4,4,4; pm_addr stops at 04; head holds oc_out=11, npc_out=01.
REQ-036 Queue full (count=4), release stall for one cycle -> exactly one pop and one push same edge; count remains 4; pm_addr 04->05.
REQ-037 flush=1, flush_addr=8'h40, in cycle t with count=3 -> t+1: valid_out=0, count=0, pm_addr=40; t+2: oc_out=PM[40], npc_out=41.
REQ-038 flush_addr=8'hFE, stall=0 -> npc_out sequence FF, 00, 01; pm_addr wraps FF->00 without glitch in count.
REQ-039 flush and rst asserted together with flush_addr=8'h80 -> next cycle pm_addr=00, count=0, valid_out=0.
